// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and defaults for the round-robin grant arbiter.
// Holds the FSM state encoding, default sizing and the index-width helper.
package rr_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int RR_N_DEFAULT       = 64;
    localparam int RR_TIMEOUT_DEFAULT = 256;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int N = RR_N_DEFAULT
);

    logic [N-1:0] req;
    logic         release_i;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         timeout_o;

    modport master (
        output req,
        output release_i,
        input  grant,
        input  grant_valid,
        input  timeout_o
    );

    modport slave (
        input  req,
        input  release_i,
        output grant,
        output grant_valid,
        output timeout_o
    );

endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// Combinational round-robin pick: lowest request strictly above ptr, else lowest overall.
// The pick vector is built from a single index, so it can never be multi-hot.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N = RR_N_DEFAULT
) (
    input  logic [N-1:0]          req,
    input  logic [idx_w(N)-1:0]   ptr,
    output logic [N-1:0]          pick,
    output logic [idx_w(N)-1:0]   pick_idx
);

    localparam int IW = idx_w(N);

    logic [N-1:0]  masked;
    logic          hit_m;
    logic [IW-1:0] idx_m;
    logic [IW-1:0] idx_u;

    // Two priority encoders: the masked one wins whenever anything sits above ptr.
    always_comb begin
        masked = '0;
        hit_m  = 1'b0;
        idx_m  = '0;
        idx_u  = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i > int'(ptr));
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx_m = IW'(i);
                hit_m = 1'b1;
            end
            if (req[i]) begin
                idx_u = IW'(i);
            end
        end
    end

    always_comb begin
        pick_idx = hit_m ? idx_m : idx_u;
        pick     = '0;
        if (|req) begin
            pick[pick_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and a 1-cycle bubble between owners.
// Optional forced revoke after TIMEOUT held cycles when RRARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N       = RR_N_DEFAULT,
    parameter int TIMEOUT = RR_TIMEOUT_DEFAULT
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    rr_grant_arbiter_if.slave  bus
);

    localparam int IW = idx_w(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] pick_idx;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  pick;
    logic          grant_valid_q;
    logic          timeout_q, timeout_d;
    logic          owner_exit;
    logic          tmo_hit;
    logic          grant_exit;

    rr_pick #(.N(N)) u_pick (
        .req      (bus.req),
        .ptr      (ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

`ifdef RRARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] hold_cnt_q;

    // Counts cycles spent in GRANT; held at zero everywhere else so each grant starts fresh.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state_q != GRANT) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_q + CW'(1);
        end
    end

    assign tmo_hit = (state_q == GRANT) && (hold_cnt_q == CW'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT;
    assign tmo_hit        = 1'b0;
`endif

    assign owner_exit = bus.release_i || !bus.req[owner_q];
    assign grant_exit = owner_exit || tmo_hit;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            ptr_q         <= IW'(N - 1);
            owner_q       <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            grant_q       <= grant_d;
            grant_valid_q <= |grant_d;
            timeout_q     <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (|bus.req)  state_d = GRANT;
            GRANT: if (grant_exit) state_d = IDLE;
        endcase
    end

    // Grant drops to zero on any exit, which also yields the bubble before the next owner.
    always_comb begin
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                grant_d = pick;
                owner_d = pick_idx;
            end
            GRANT: begin
                if (grant_exit) begin
                    grant_d   = '0;
                    ptr_d     = owner_q;
                    timeout_d = tmo_hit && !owner_exit;
                end
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.timeout_o   = timeout_q;

    grant_onehot: assert property (@(posedge wb_clk_i) $onehot0(grant_q));

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scoreboard bench for rr_grant_arbiter (N=64, TIMEOUT=8); honours RRARB_TIMEOUT_EN.
module tb_rr_grant_arbiter;

    logic wb_clk_i;
    logic wb_rst_i;
    int   checks;
    int   failures;
    logic mon_en;

    logic [63:0] exp_grant_q[$];
    logic        exp_tmo_q[$];

    rr_grant_arbiter_if #(.N(64)) bus ();

    rr_grant_arbiter #(.N(64), .TIMEOUT(8)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // The grant must never be multi-hot, whatever the stimulus.
    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            checks++;
            assert ($onehot0(bus.grant)) else begin
                failures++;
                $error("[TB] FAIL onehot0 grant got=%h", bus.grant);
            end
        end
    end

    task automatic checkOutput(input string tag);
        logic [63:0] eg;
        logic        et;
        if (exp_grant_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard empty", tag);
            return;
        end
        eg = exp_grant_q.pop_front();
        et = exp_tmo_q.pop_front();
        checks++;
        assert (bus.grant === eg) else begin
            failures++;
            $error("[TB] FAIL %s grant got=%h exp=%h", tag, bus.grant, eg);
        end
        checks++;
        assert (bus.grant_valid === (|eg)) else begin
            failures++;
            $error("[TB] FAIL %s grant_valid got=%b exp=%b", tag, bus.grant_valid, |eg);
        end
        checks++;
        assert (bus.timeout_o === et) else begin
            failures++;
            $error("[TB] FAIL %s timeout_o got=%b exp=%b", tag, bus.timeout_o, et);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [63:0] r, input logic rel,
                                 input logic [63:0] eg, input logic et, input string tag);
        wb_rst_i      = rst;
        bus.req       = r;
        bus.release_i = rel;
        exp_grant_q.push_back(eg);
        exp_tmo_q.push_back(et);
        @(posedge wb_clk_i);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        logic [63:0] ones;
        logic [63:0] one;
        logic [63:0] b63;
        logic [63:0] b3;
        logic [63:0] b1;
        logic [63:0] b5;
        ones = '1;
        one  = 64'd1;
        b63  = one << 63;
        b3   = one << 3;
        b1   = one << 1;
        b5   = one << 5;
        checks   = 0;
        failures = 0;
        mon_en   = 1'b0;
        wb_rst_i      = 1'b1;
        bus.req       = '0;
        bus.release_i = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, "rst_idle");
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, ones, 1'b0, '0, 1'b0, "rst_req_all");

        // single requester, release, then ptr=5 shows up as bit 6 winning
        applyStimulus(1'b0, 64'h20, 1'b0, 64'h20, 1'b0, "single_grant");
        applyStimulus(1'b0, 64'h20, 1'b0, 64'h20, 1'b0, "single_hold");
        applyStimulus(1'b0, 64'h20, 1'b1, '0, 1'b0, "single_release");
        applyStimulus(1'b0, ones, 1'b0, one << 6, 1'b0, "after_ptr5");
        applyStimulus(1'b0, ones, 1'b1, '0, 1'b0, "after_ptr5_rel");

        // full rotation from a fresh reset, one bubble between owners
        applyStimulus(1'b1, '0, 1'b0, '0, 1'b0, "rst_rotate");
        for (int i = 0; i <= 64; i++) begin
            applyStimulus(1'b0, ones, 1'b0, one << (i % 64), 1'b0, "rotate_grant");
            applyStimulus(1'b0, ones, 1'b1, '0, 1'b0, "rotate_bubble");
        end

        // wrap: owner 63 then {63,0} -> 0 first, then 63
        applyStimulus(1'b0, b63, 1'b0, b63, 1'b0, "own63");
        applyStimulus(1'b0, b63, 1'b1, '0, 1'b0, "own63_rel");
        applyStimulus(1'b0, b63 | one, 1'b0, one, 1'b0, "wrap_bit0");
        applyStimulus(1'b0, b63 | one, 1'b1, '0, 1'b0, "wrap_bit0_rel");
        applyStimulus(1'b0, b63 | one, 1'b0, b63, 1'b0, "wrap_bit63");
        applyStimulus(1'b0, b63 | one, 1'b1, '0, 1'b0, "wrap_bit63_rel");

        // owner drop, request churn during grant, release ignored in IDLE
        applyStimulus(1'b0, b3, 1'b0, b3, 1'b0, "own3");
        applyStimulus(1'b0, b3 | b1, 1'b0, b3, 1'b0, "own3_churn");
        applyStimulus(1'b0, b1, 1'b0, '0, 1'b0, "own3_drop");
        applyStimulus(1'b0, '0, 1'b1, '0, 1'b0, "idle_release");
        applyStimulus(1'b0, b5, 1'b1, b5, 1'b0, "idle_release_ignored");
        applyStimulus(1'b0, b5, 1'b1, '0, 1'b0, "rel_with_req");
        applyStimulus(1'b0, b3, 1'b0, b3, 1'b0, "own3_again");
        applyStimulus(1'b1, ones, 1'b0, '0, 1'b0, "rst_mid_grant");
        applyStimulus(1'b0, ones, 1'b0, one, 1'b0, "post_rst_bit0");
        applyStimulus(1'b0, ones, 1'b1, '0, 1'b0, "post_rst_rel");

        // held request without release
`ifdef RRARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, one, 1'b0, one, 1'b0, "tmo_hold");
        applyStimulus(1'b0, one, 1'b0, '0, 1'b1, "tmo_revoke");
        applyStimulus(1'b0, one, 1'b0, one, 1'b0, "tmo_regrant");
        applyStimulus(1'b0, one, 1'b1, '0, 1'b0, "tmo_release");
`else
        for (int i = 0; i < 1000; i++) applyStimulus(1'b0, one, 1'b0, one, 1'b0, "hold_forever");
        applyStimulus(1'b0, one, 1'b1, '0, 1'b0, "hold_release");
`endif

        checks++;
        assert (exp_grant_q.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_drain left=%0d exp=0", exp_grant_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
